pattern_sender: RTL



---
 rtl/pattern_sender.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pattern_sender.sv
// -----------------------------------------------------------------------------
// pattern_sender
//
// Serial transmitter for short switch-pattern codes. A start request latches a
// WIDTH-bit code and a frame count, then shifts the code out MSB first once per
// frame. Consecutive frames are separated by GAP_CYCLES idle cycles, and a
// one-cycle done pulse follows the last frame.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   start         transmit request, only looked at while idle
//   code          pattern to send, captured when start is accepted
//   repeat_count  number of frames to send, captured when start is accepted
//   serial_out    current serial bit (0 whenever bit_valid is low)
//   bit_valid     serial_out carries a code bit
//   frame_start   one-cycle pulse alongside the MSB of every frame
//   busy          transmitter is shifting or waiting in an inter-frame gap
//   done          one-cycle pulse after the last frame has been sent
//
// Timing: every output is a register loaded from a decode of the current
// state, so outputs trail the state by one cycle. For a start accepted at
// edge T the MSB is visible after edge T+1, frame k starts after edge
// T+1+k*(WIDTH+GAP_CYCLES), and done is visible the cycle after the final bit.
// -----------------------------------------------------------------------------
module pattern_sender #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] code,
  input  logic [CNT_W-1:0] repeat_count,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  // Bit index only ever needs to address WIDTH positions.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Gap counter counts GAP_CYCLES-1 down to 0.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_code;
  logic [CNT_W-1:0] r_frames;    // frames still to send, including current one
  logic [IDX_W-1:0] r_bit_idx;
  logic [GAP_W-1:0] r_gap_cnt;

  // Registered outputs
  logic r_serial_out;
  logic r_bit_valid;
  logic r_frame_start;
  logic r_busy;
  logic r_done;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t           w_state_next;
  logic [WIDTH-1:0] w_code_next;
  logic [CNT_W-1:0] w_frames_next;
  logic [IDX_W-1:0] w_bit_idx_next;
  logic [GAP_W-1:0] w_gap_cnt_next;

  logic w_serial_out;
  logic w_bit_valid;
  logic w_frame_start;
  logic w_busy;
  logic w_done;

  // Current code bit, selected by the bit index.
  logic w_code_bit;
  assign w_code_bit = r_code[r_bit_idx];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_code_next    = r_code;
    w_frames_next  = r_frames;
    w_bit_idx_next = r_bit_idx;
    w_gap_cnt_next = r_gap_cnt;

    w_serial_out   = 1'b0;
    w_bit_valid    = 1'b0;
    w_frame_start  = 1'b0;
    w_busy         = 1'b0;
    w_done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_code_next   = code;
          w_frames_next = repeat_count;
          if (repeat_count == CNT_ZERO) begin
            // Nothing to send: report completion straight away.
            w_state_next = S_DONE;
          end else begin
            w_state_next   = S_SHIFT;
            w_bit_idx_next = IDX_MSB;
          end
        end
      end

      S_SHIFT: begin
        w_serial_out  = w_code_bit;
        w_bit_valid   = 1'b1;
        w_busy        = 1'b1;
        w_frame_start = (r_bit_idx == IDX_MSB);

        if (r_bit_idx == '0) begin
          // End of frame. The frame counter saturates at zero; the bit
          // index is left at zero and only reloaded when SHIFT is re-entered.
          w_frames_next = (r_frames != CNT_ZERO) ? (r_frames - CNT_ONE) : CNT_ZERO;
          if (r_frames > CNT_ONE) begin
            w_state_next   = S_GAP;
            w_gap_cnt_next = GAP_LOAD;
          end else begin
            w_state_next = S_DONE;
          end
        end else begin
          w_bit_idx_next = r_bit_idx - IDX_W'(1);
        end
      end

      S_GAP: begin
        w_busy = 1'b1;
        if (r_gap_cnt == '0) begin
          w_state_next   = S_SHIFT;
          w_bit_idx_next = IDX_MSB;
        end else begin
          w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
        end
      end

      S_DONE: begin
        // start is deliberately not examined here; a held request is taken
        // in the following IDLE cycle.
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register; reset clears state, counters and every output together,
  // so an abort mid-frame produces no trailing done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_code        <= '0;
      r_frames      <= '0;
      r_bit_idx     <= '0;
      r_gap_cnt     <= '0;
      r_serial_out  <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_code        <= w_code_next;
      r_frames      <= w_frames_next;
      r_bit_idx     <= w_bit_idx_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_serial_out  <= w_serial_out;
      r_bit_valid   <= w_bit_valid;
      r_frame_start <= w_frame_start;
      r_busy        <= w_busy;
      r_done        <= w_done;
    end
  end

  assign serial_out  = r_serial_out;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
